// File: rtl/syncer_pkg.sv
// Shared types and constants for the handshaked bus synchronizer and its level synchronizer.
`timescale 1ns/1ps
package syncer_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } src_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } dst_state_e;

endpackage

// File: rtl/syncer_level.sv
// Multi-flop level synchronizer; brings a slowly changing bit into the clk domain, resetting to 0.
`timescale 1ns/1ps
module syncer_level
    import syncer_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_level,
    output logic sync_level
);

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], async_level};
        end
    end

    assign sync_level = stage_reg[STAGES-1];

endmodule

// File: rtl/syncer_bus_hs.sv
// Handshaked word transfer from clkin to clkout using a toggle req/ack pair.
// Optional even parity on the held word is enabled by defining SYNCER_BUS_HS_PARITY_EN.
`timescale 1ns/1ps
module syncer_bus_hs
    import syncer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clkin,
    input  logic             clkin_resetn,
    input  logic             clkout,
    input  logic             clkout_resetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             in_done,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr
);

    // clkin domain
    src_state_e       src_state_reg, src_state_next;
    logic             req_reg, req_next;
    logic             src_up_reg;
    logic             in_done_reg, in_done_next;
    logic [WIDTH-1:0] hold_data_reg, hold_data_next;
    logic             sync_ack;

    // clkout domain
    dst_state_e       dst_state_reg, dst_state_next;
    logic             ack_reg, ack_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             sync_req;
    logic             sync_src_up;

`ifdef SYNCER_BUS_HS_PARITY_EN
    logic             hold_par_reg, hold_par_next;
    logic             out_perr_reg, out_perr_next;
`endif

    syncer_level #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk         (clkout),
        .resetn      (clkout_resetn),
        .async_level (req_reg),
        .sync_level  (sync_req)
    );

    syncer_level #(.STAGES(SYNC_STAGES)) u_sync_src_up (
        .clk         (clkout),
        .resetn      (clkout_resetn),
        .async_level (src_up_reg),
        .sync_level  (sync_src_up)
    );

    syncer_level #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk         (clkin),
        .resetn      (clkin_resetn),
        .async_level (ack_reg),
        .sync_level  (sync_ack)
    );

    // src_up keeps in_ready low for the first cycle out of reset
    assign in_ready = (src_state_reg == IDLE) && src_up_reg;
    assign in_done  = in_done_reg;

    always_comb begin
        src_state_next = src_state_reg;
        req_next       = req_reg;
        hold_data_next = hold_data_reg;
        in_done_next   = 1'b0;
`ifdef SYNCER_BUS_HS_PARITY_EN
        hold_par_next  = hold_par_reg;
`endif
        case (src_state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    src_state_next = BUSY;
                    req_next       = ~req_reg;
                    hold_data_next = in_data;
`ifdef SYNCER_BUS_HS_PARITY_EN
                    hold_par_next  = ^in_data;
`endif
                end
            end
            BUSY: begin
                if (sync_ack == req_reg) begin
                    src_state_next = IDLE;
                    in_done_next   = 1'b1;
                end
            end
            default: src_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge clkin_resetn) begin
        if (!clkin_resetn) begin
            src_state_reg <= IDLE;
            req_reg       <= 1'b0;
            src_up_reg    <= 1'b0;
            in_done_reg   <= 1'b0;
            hold_data_reg <= '0;
`ifdef SYNCER_BUS_HS_PARITY_EN
            hold_par_reg  <= 1'b0;
`endif
        end else begin
            src_state_reg <= src_state_next;
            req_reg       <= req_next;
            src_up_reg    <= 1'b1;
            in_done_reg   <= in_done_next;
            hold_data_reg <= hold_data_next;
`ifdef SYNCER_BUS_HS_PARITY_EN
            hold_par_reg  <= hold_par_next;
`endif
        end
    end

    assign out_valid = (dst_state_reg == FULL);
    assign out_data  = out_data_reg;
`ifdef SYNCER_BUS_HS_PARITY_EN
    assign out_perr  = out_perr_reg;
`else
    assign out_perr  = 1'b0;
`endif

    // hold register is static while req and ack differ, so sampling it here is safe
    always_comb begin
        dst_state_next = dst_state_reg;
        ack_next       = ack_reg;
        out_data_next  = out_data_reg;
`ifdef SYNCER_BUS_HS_PARITY_EN
        out_perr_next  = out_perr_reg;
`endif
        case (dst_state_reg)
            EMPTY: begin
                if ((sync_req != ack_reg) && sync_src_up) begin
                    dst_state_next = FULL;
                    out_data_next  = hold_data_reg;
`ifdef SYNCER_BUS_HS_PARITY_EN
                    out_perr_next  = (^hold_data_reg) != hold_par_reg;
`endif
                end
            end
            FULL: begin
                if (out_ready) begin
                    dst_state_next = EMPTY;
                    ack_next       = ~ack_reg;
`ifdef SYNCER_BUS_HS_PARITY_EN
                    out_perr_next  = 1'b0;
`endif
                end
            end
            default: dst_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clkout or negedge clkout_resetn) begin
        if (!clkout_resetn) begin
            dst_state_reg <= EMPTY;
            ack_reg       <= 1'b0;
            out_data_reg  <= '0;
`ifdef SYNCER_BUS_HS_PARITY_EN
            out_perr_reg  <= 1'b0;
`endif
        end else begin
            dst_state_reg <= dst_state_next;
            ack_reg       <= ack_next;
            out_data_reg  <= out_data_next;
`ifdef SYNCER_BUS_HS_PARITY_EN
            out_perr_reg  <= out_perr_next;
`endif
        end
    end

endmodule

// File: tb/tb_syncer_bus_hs.sv
// Scoreboard bench for syncer_bus_hs: words queued at acceptance, popped at delivery.
`timescale 1ns/1ps
module tb_syncer_bus_hs;

    localparam int WIDTH = 8;

    logic             clkin = 1'b0;
    logic             clkout = 1'b0;
    logic             clkin_resetn = 1'b1;
    logic             clkout_resetn = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_done;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_perr;

    // clkin edges land on whole ns, clkout edges on a .x7-type fraction, so they never coincide
    realtime in_half  = 5.0;
    realtime out_half = 6.55;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];

    syncer_bus_hs #(.WIDTH(WIDTH)) dut (
        .clkin         (clkin),
        .clkin_resetn  (clkin_resetn),
        .clkout        (clkout),
        .clkout_resetn (clkout_resetn),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_done       (in_done),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_perr      (out_perr)
    );

    initial forever #(in_half) clkin = ~clkin;
    initial begin
        #0.37;
        forever #(out_half) clkout = ~clkout;
    end

    always @(negedge clkin) if (in_done) done_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offers w until accepted; returns right at the accepting clkin edge.
    task automatic send_word(input logic [WIDTH-1:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clkin);
            in_valid = 1'b1;
            in_data  = w;
            if (in_ready) begin
                exp_q.push_back(w);
                @(posedge clkin);
                ok = 1'b1;
            end
        end
        fork
            begin
                #1;
                in_valid = 1'b0;
            end
        join_none
    endtask

    task automatic wait_out_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clkout);
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        clkin_resetn  = 1'b0;
        clkout_resetn = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (4) @(posedge clkin);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (in_done !== 1'b0) begin bad++; $display("FAIL reset_in_done: got %b want 0", in_done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        total++; if (out_perr !== 1'b0) begin bad++; $display("FAIL reset_out_perr: got %b want 0", out_perr); end
        @(negedge clkin);
        clkin_resetn  = 1'b1;
        clkout_resetn = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready_early: got %b want 0", in_ready); end
        @(posedge clkin);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready_edge1: got %b want 1", in_ready); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clkout);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid: cycle %0d got %b want 0", i, out_valid); end
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        bit ok;
        int edges;
        int d0;
        logic [WIDTH-1:0] exp;
        in_half   = 5.0;
        out_half  = 6.55;
        out_ready = 1'b1;
        d0 = done_cnt;
        edges = 0;
        send_word(8'hA5, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_accept: got no accept want accept"); end
        for (int k = 1; k <= 8 && edges == 0; k++) begin
            @(posedge clkout);
            #0.1;
            if (out_valid) edges = k;
        end
        total++; if (edges != 3) begin bad++; $display("FAIL single_latency: got %0d clkout edges want 3", edges); end
        if (exp_q.size() == 0) begin
            total++; bad++; $display("FAIL single_queue: got empty scoreboard want 1 entry");
        end else begin
            exp = exp_q.pop_front();
            total++; if (out_data !== exp) begin bad++; $display("FAIL single_data: got %h want %h", out_data, exp); end
        end
        @(posedge clkout);
        #0.1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_width: got %b want 0 after one cycle", out_valid); end
        repeat (20) @(negedge clkin);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done: got %0d pulses want 1", done_cnt - d0); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready_after: got %b want 1", in_ready); end
        $display("test_single: word a5 latency %0d", edges);
    endtask

    task automatic test_backpressure();
        bit ok;
        int d0;
        logic [WIDTH-1:0] exp;
        out_ready = 1'b0;
        d0 = done_cnt;
        send_word(8'h3C, ok);
        wait_out_valid(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_valid: got no out_valid want out_valid"); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clkout);
            total++;
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 8'h3C}) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d got valid=%b ready=%b data=%h want 1 0 3c", i, out_valid, in_ready, out_data);
            end
        end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL bp_done_early: got %0d pulses want 0", done_cnt - d0); end
        @(negedge clkout);
        out_ready = 1'b1;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        total++; if (out_data !== exp) begin bad++; $display("FAIL bp_data: got %h want %h", out_data, exp); end
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clkin);
            if (done_cnt - d0 == 1) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt - d0); end
        $display("test_backpressure: word 3c released");
    endtask

    task automatic test_back_to_back(input realtime ih, input realtime oh);
        int n;
        int got;
        int d0;
        repeat (4) @(negedge clkin);
        in_half  = ih;
        out_half = oh;
        repeat (4) @(negedge clkin);
        exp_q.delete();
        d0 = done_cnt;
        n = 0;
        got = 0;
        fork
            begin
                for (int c = 0; c < 20000 && n < 256; c++) begin
                    @(negedge clkin);
                    in_valid = 1'b1;
                    in_data  = n[WIDTH-1:0];
                    if (in_ready) begin
                        exp_q.push_back(n[WIDTH-1:0]);
                        n++;
                    end
                end
                @(posedge clkin);
                #1;
                in_valid = 1'b0;
            end
            begin
                logic [WIDTH-1:0] exp;
                for (int c = 0; c < 20000 && got < 256; c++) begin
                    @(negedge clkout);
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL b2b_extra: got word %h want nothing", out_data);
                        end else begin
                            exp = exp_q.pop_front();
                            total++;
                            if ({out_perr, out_data} !== {1'b0, exp}) begin
                                bad++;
                                $display("FAIL b2b_word: got perr=%b data=%h want 0 %h", out_perr, out_data, exp);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        repeat (30) @(negedge clkin);
        total++; if (got != 256) begin bad++; $display("FAIL b2b_count: got %0d words want 256", got); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d undelivered want 0", exp_q.size()); end
        total++; if (done_cnt - d0 != 256) begin bad++; $display("FAIL b2b_done: got %0d pulses want 256", done_cnt - d0); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_dup: got out_valid %b want 0 after stream", out_valid); end
        $display("test_back_to_back: in_half=%0.2f out_half=%0.2f words=%0d", ih, oh, got);
    endtask

`ifdef SYNCER_BUS_HS_PARITY_EN
    task automatic test_parity();
        bit ok;
        logic [WIDTH-1:0] exp;
        out_ready = 1'b0;
        send_word(8'h11, ok);
        #1;
        force dut.hold_par_reg = 1'b1;
        wait_out_valid(30, ok);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        total++; if ({out_valid, out_perr, out_data} !== {1'b1, 1'b1, exp}) begin
            bad++; $display("FAIL parity_err: got valid=%b perr=%b data=%h want 1 1 %h", out_valid, out_perr, out_data, exp);
        end
        release dut.hold_par_reg;
        out_ready = 1'b1;
        @(negedge clkout);
        total++; if ({out_valid, out_perr} !== 2'b00) begin bad++; $display("FAIL parity_clear: got valid=%b perr=%b want 0 0", out_valid, out_perr); end
        send_word(8'h12, ok);
        wait_out_valid(30, ok);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        total++; if ({out_valid, out_perr, out_data} !== {1'b1, 1'b0, exp}) begin
            bad++; $display("FAIL parity_next: got valid=%b perr=%b data=%h want 1 0 %h", out_valid, out_perr, out_data, exp);
        end
        repeat (20) @(negedge clkin);
        $display("test_parity: flipped bit flagged on word 11 only");
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        int got;
        logic [WIDTH-1:0] exp;
        in_half   = 5.0;
        out_half  = 6.55;
        repeat (4) @(negedge clkin);
        out_ready = 1'b0;
        exp_q.delete();
        send_word(8'h77, ok);
        wait_out_valid(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_full: got no out_valid want out_valid"); end
        @(negedge clkin);
        #2;
        clkin_resetn  = 1'b0;
        clkout_resetn = 1'b0;
        #1;
        total++;
        if ({in_ready, in_done, out_valid, out_data, out_perr} !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset: got ready=%b done=%b valid=%b data=%h perr=%b want all 0", in_ready, in_done, out_valid, out_data, out_perr);
        end
        exp_q.delete();
        repeat (5) @(negedge clkin);
        clkin_resetn  = 1'b1;
        clkout_resetn = 1'b1;
        out_ready = 1'b1;
        send_word(8'h5A, ok);
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clkout);
            if (out_valid && out_ready) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                total++; if (out_data !== exp) begin bad++; $display("FAIL mid_word: got %h want %h", out_data, exp); end
                got++;
            end
        end
        total++; if (got != 1) begin bad++; $display("FAIL mid_count: got %0d deliveries want 1", got); end
        $display("test_reset_mid: deliveries after reset %0d", got);
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back(5.0, 15.05);
        test_back_to_back(15.0, 5.05);
`ifdef SYNCER_BUS_HS_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
